uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
UART receiver for the soft AVR I/O subsystem. It is the receive end of the serial link whose transmit side already drives uart_tx. The block oversamples the uart_rx pin at 16x, deframes 8N1 characters and buffers them in a small FIFO. The io block pops bytes through a UDR-style read strobe and reads RXC/FE/DOR status bits for its status register and its RX-complete IRQ request.

Parameters:
BAUD_DIV, 81, clk cycles per 16x oversample tick (12.5 MHz hclk / (9600*16)); legal range 1..65535
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16

Ports:
clk  input  1  system clock (hclk domain)
rst  input  1  synchronous reset, active-high
rx  input  1  asynchronous serial input, idle high
rd  input  1  pop strobe, one clk pulse per UDR read
dout  output  8  head-of-FIFO data byte
fe  output  1  frame error flag of the head entry
rxc  output  1  FIFO not empty (RX complete)
dor  output  1  data overrun, sticky
count  output  $clog2(FIFO_DEPTH)+1  number of stored entries

Behaviour:
- Reset: synchronous and active-high. All outputs go to 0: dout=0, fe=0, rxc=0, dor=0, count=0. State goes to IDLE, the tick divider and FIFO pointers clear, and both synchroniser flops are set to 1.
- Reset mid-frame aborts the frame. No partial byte is pushed.
- rx passes through a 2-FF synchroniser. All logic uses the synchronised value rx_s.
- Tick generator: a 16-bit counter counts 0..BAUD_DIV-1 and pulses tick for one clk cycle on wrap. It free-runs and is reset to 0 when a start edge is detected, so sampling is phase-aligned.
- Sample counter: 4 bits, advances on each tick and wraps 15->0. One bit period is 16 ticks.
- FSM, states IDLE, START, DATA, STOP:
  - IDLE: on a 1->0 transition of rx_s, go to START and clear the sample counter.
  - START: at sample 8, if the majority vote is 0 go to DATA with bit index 0. Otherwise this is a false start: return to IDLE with no push.
  - DATA: at sample 8 of each bit, shift the majority vote into the shift register LSB-first. After bit index 7, go to STOP.
  - STOP: at sample 8, push {fe_bit = ~vote, shift register} and go to IDLE immediately, half a bit early, so back-to-back frames are accepted.
- Majority vote: 2-of-3 over rx_s captured at samples 7, 8 and 9. The decision is taken on the sample-9 tick; "sample 8" above means this decision point.
- FIFO: DEPTH x 9-bit register array, with read and write pointers one bit wider than the address.
  - Push and pop each take effect on the clk edge.
  - dout and fe show the head entry combinationally from the array and are don't-care while rxc=0. The bench must not check them then.
  - rxc = (count != 0). It rises on the clk edge after the push cycle, so latency from the stop-bit decision to rxc=1 is 1 clk.
  - rd while empty is ignored: no pointer change, no underflow.
  - Push while full: if rd is also asserted in the same cycle, the pop and the push both happen and count is unchanged. Otherwise the new byte is dropped, the FIFO is unchanged, and dor is set.
  - dor stays set until the next accepted rd, which clears it. A new overrun in the same cycle as that clearing rd wins, and dor stays 1.
- Pointer and count wrap is modulo 2*FIFO_DEPTH. Full = (wptr ^ rptr) == FIFO_DEPTH.

Decomposition:
- Constants (state encodings, SAMPLE_MID=8, DATA_BITS=8) go in the shared avr_io_pkg include alongside the other io constants.
- One sub-module, sync_fifo (parameterised width and depth, with push, pop, full, empty and count). It is reused for the future TX buffer.
- The oversampler and FSM stay in uart_rx_fifo.

Test Plan:
- 0x55 sent 8N1 at the BAUD_DIV rate -> rxc=1 within 1 clk of the stop-bit decision; dout=0x55, fe=0, count=1. After rd: rxc=0, count=0.
- rx low for 3 ticks, then high (glitch) -> no push; FSM back in IDLE; rxc stays 0.
- 0xA3 with the stop bit driven 0, then line returned high -> dout=0xA3, fe=1. A following good frame 0x3C, after rd -> dout=0x3C, fe=0.
- Five back-to-back frames 0x01..0x05 with no rd -> count=4, dor=1; popping yields 0x01..0x04, and 0x05 is never seen. After the first rd, dor=0.
- FIFO full, with rd asserted in the exact cycle of a push of 0x77 -> count stays 4, dor=0; 0x77 is the last byte popped.
- rst asserted during bit 4 of a frame, released, then 0x9C sent -> only 0x9C is received; all outputs read 0 during reset.

Source files
------------

// File: rtl/avr_io_pkg.sv
// avr_io_pkg: shared constants, states and helpers for the AVR I/O subsystem
package avr_io_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam int DATA_BITS = 8;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-array FIFO with pointers one bit wider than the address
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic pop_ok, push_ok;
  assign count = wptr - rptr;
  assign empty = count == '0;
  assign full = (wptr ^ rptr) == (AW+1)'(DEPTH);
  assign pop_ok = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push && (!full || pop_ok);
  assign dout = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + ONE;
      if (pop_ok) rptr <= rptr + ONE;
    end
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling 8N1 UART receiver feeding a small receive FIFO
module uart_rx_fifo
  import avr_io_pkg::*;
#(
  parameter int BAUD_DIV   = 81,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd,
  output logic [7:0]                    dout,
  output logic                          fe,
  output logic                          rxc,
  output logic                          dor,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam logic [15:0] DIV_MAX = 16'(BAUD_DIV - 1);
  rx_state_t state, state_n;
  logic rx_q, rx_s, rx_d, tick, start_edge, decide, vote, push, full, empty, overrun;
  logic [15:0] div;
  logic [3:0] sample;
  logic [1:0] votes;
  logic [2:0] idx;
  logic [DATA_BITS-1:0] shift;
  assign tick = div == DIV_MAX;
  assign start_edge = state == IDLE && rx_d && !rx_s;
  // the vote completes on the tick after the mid-bit sample
  assign decide = tick && sample == SAMPLE_MID + 4'd1;
  assign vote = maj3(votes[0], votes[1], rx_s);
  assign push = decide && state == STOP;
  assign overrun = push && full && !rd;
  assign rxc = !empty;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start_edge) state_n = START;
      START: if (decide) state_n = vote ? IDLE : DATA;
      DATA:  if (decide && idx == 3'(DATA_BITS - 1)) state_n = STOP;
      STOP:  if (decide) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      div <= '0;
      sample <= '0;
      votes <= '0;
      idx <= '0;
      shift <= '0;
      dor <= 1'b0;
    end else begin
      rx_q <= rx;
      rx_s <= rx_q;
      rx_d <= rx_s;
      div <= (start_edge || tick) ? '0 : div + 16'd1;
      sample <= start_edge ? '0 : tick ? sample + 4'd1 : sample;
      if (tick && sample == SAMPLE_MID - 4'd1) votes[0] <= rx_s;
      if (tick && sample == SAMPLE_MID) votes[1] <= rx_s;
      if (decide && state == DATA) shift <= {vote, shift[DATA_BITS-1:1]};
      idx <= state != DATA ? '0 : decide ? idx + 3'd1 : idx;
      dor <= overrun || (dor && !(rd && rxc));
    end
  end
  sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd),
    .din   ({~vote, shift}),
    .dout  ({fe, dout}),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule
